mul_div_unit: RTL

Iterative RV32M multiply/divide unit that sits beside the combinational ALU in the data path. It takes the same `srcA`/`srcB` operands, replaces single-cycle evaluation with a start/done handshake, and computes all eight M-extension operations. The result is ready a fixed number of cycles after start. The control unit stalls the pipeline while `busy` is high.

---
 rtl/mul_div_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, start/done handshake.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and MUL-by-zero finish in 2 cycles.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic [2:0]      operation,
    output logic [XLEN-1:0] res,
    output logic            flag,
    output logic            busy,
    output logic            done
);
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;
    localparam logic [4:0] LAST_ITER = 5'(XLEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_FIX, S_RDY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              flag_q, flag_d, busy_q, busy_d, done_q, done_d;

    // Operand decode at acceptance
    logic            a_signed_in, b_signed_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in;

    always_comb begin
        a_signed_in = (operation != OP_MULHU) && (operation != OP_DIVU) && (operation != OP_REMU);
        b_signed_in = a_signed_in && (operation != OP_MULHSU);
        mag_a_in    = (a_signed_in && srcA[XLEN-1]) ? -srcA : srcA;
        mag_b_in    = (b_signed_in && srcB[XLEN-1]) ? -srcB : srcB;
    end

    // Iteration datapath: acc holds {partial product, multiplier} or {remainder, quotient}
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     rem_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_step;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        mul_step = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        div_ge   = rem_sh >= {1'b0, mag_b_q};
        div_diff = rem_sh[XLEN-1:0] - mag_b_q;
        div_step = {div_ge ? div_diff : rem_sh[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, a_raw, fix_res;
    logic              div_zero, fix_flag;

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        a_raw    = sign_a_q ? -mag_a_q : mag_a_q;
        div_zero = (mag_b_q == '0);
        fix_flag = op_q[2] && div_zero;
        case (op_q)
            OP_MUL:          fix_res = prod_fix[XLEN-1:0];
            OP_DIV, OP_DIVU: fix_res = div_zero ? '1 : quo_fix;
            OP_REM, OP_REMU: fix_res = div_zero ? a_raw : rem_fix;
            default:         fix_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            ovf, mul_zero, early;
    logic [XLEN-1:0] early_res;

    always_comb begin
        ovf      = (op_q == OP_DIV || op_q == OP_REM) && sign_a_q && sign_b_q
                   && (mag_a_q == {1'b1, {(XLEN-1){1'b0}}}) && (mag_b_q == XLEN'(1));
        mul_zero = (op_q == OP_MUL) && (mag_a_q == '0 || mag_b_q == '0);
        early    = fix_flag || ovf || mul_zero;
        if (mul_zero)
            early_res = '0;
        else if (div_zero)
            early_res = op_q[1] ? a_raw : '1;
        else
            early_res = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        res_d    = res_q;
        flag_d   = flag_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    op_d     = operation;
                    sign_a_d = a_signed_in && srcA[XLEN-1];
                    sign_b_d = b_signed_in && srcB[XLEN-1];
                    mag_a_d  = mag_a_in;
                    mag_b_d  = mag_b_in;
                    acc_d    = {{XLEN{1'b0}}, operation[2] ? mag_a_in : mag_b_in};
                    busy_d   = 1'b1;
                end
            end
            S_CALC: begin
`ifdef MULDIV_EARLY_OUT_EN
                if (cnt_q == '0 && early) begin
                    res_d   = early_res;
                    flag_d  = fix_flag;
                    state_d = S_RDY;
                end else
`endif
                begin
                    acc_d = op_q[2] ? div_step : mul_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER)
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                res_d   = fix_res;
                flag_d  = fix_flag;
                state_d = S_RDY;
            end
            S_RDY: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            flag_q   <= flag_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign res  = res_q;
    assign flag = flag_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
